// File: rtl/cac_key_loader.sv
// Serial key loader: shifts a key frame plus a 4-bit XOR-fold checksum over a
// valid/ready link, commits verified keys, and locks out after repeated failures.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start; key_out holds the last committed key
// SHIFT_KEY | accepting key bits LSB first into the shadow register
// SHIFT_CHK | accepting the 4 checksum bits LSB first
// CHECK     | one cycle: compare checksum, commit key or count a failure
// LOCKOUT   | too many consecutive failures; only rst_n leaves this state
module cac_key_loader #(
  parameter int KEY_W    = 16,
  parameter int MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err_pulse,
  output logic             locked_out
);

  localparam int CNT_W  = $clog2(KEY_W);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam logic [FAIL_W-1:0] MAX_FAIL_V = FAIL_W'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_KEY = 3'd1,
    SHIFT_CHK = 3'd2,
    CHECK     = 3'd3,
    LOCKOUT   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [3:0]         chk_q, chk_d;
  logic [KEY_W-1:0]   key_out_q, key_out_d;
  logic               key_valid_q, key_valid_d;
  logic               err_pulse_q, err_pulse_d;
  logic               locked_out_q, locked_out_d;
  logic [FAIL_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [FAIL_W-1:0]  fail_next;
  logic [3:0]         exp_chk;
  logic               accept;

  assign s_ready = (state_q == SHIFT_KEY) || (state_q == SHIFT_CHK);
  assign busy    = s_ready || (state_q == CHECK);
  assign accept  = s_valid && s_ready;

  always_comb begin
    exp_chk = '0;
    for (int i = 0; i < KEY_W / 4; i++) begin
      exp_chk = exp_chk ^ shadow_q[i*4 +: 4];
    end
  end

  assign fail_next = fail_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shadow_d     = shadow_q;
    chk_d        = chk_q;
    key_out_d    = key_out_q;
    key_valid_d  = key_valid_q;
    err_pulse_d  = 1'b0;
    locked_out_d = locked_out_q;
    fail_cnt_d   = fail_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SHIFT_KEY;
          bit_cnt_d   = '0;
          key_out_d   = '0;
          key_valid_d = 1'b0;
        end
      end
      SHIFT_KEY: begin
        if (accept) begin
          shadow_d[bit_cnt_q] = s_data;
          if (bit_cnt_q == CNT_W'(KEY_W - 1)) begin
            state_d   = SHIFT_CHK;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      SHIFT_CHK: begin
        if (accept) begin
          chk_d[bit_cnt_q[1:0]] = s_data;
          if (bit_cnt_q == CNT_W'(3)) begin
            state_d   = CHECK;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      CHECK: begin
        if (chk_q == exp_chk) begin
          key_out_d   = shadow_q;
          key_valid_d = 1'b1;
          fail_cnt_d  = '0;
          state_d     = IDLE;
        end else begin
          // key_out was already cleared at start, so a failure leaves it zero
          err_pulse_d = 1'b1;
          fail_cnt_d  = fail_next;
          if (fail_next == MAX_FAIL_V) begin
            locked_out_d = 1'b1;
            state_d      = LOCKOUT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LOCKOUT: begin
        locked_out_d = 1'b1;
        key_out_d    = '0;
        key_valid_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shadow_q     <= '0;
      chk_q        <= '0;
      key_out_q    <= '0;
      key_valid_q  <= 1'b0;
      err_pulse_q  <= 1'b0;
      locked_out_q <= 1'b0;
      fail_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shadow_q     <= shadow_d;
      chk_q        <= chk_d;
      key_out_q    <= key_out_d;
      key_valid_q  <= key_valid_d;
      err_pulse_q  <= err_pulse_d;
      locked_out_q <= locked_out_d;
      fail_cnt_q   <= fail_cnt_d;
    end
  end

  assign key_out    = key_out_q;
  assign key_valid  = key_valid_q;
  assign err_pulse  = err_pulse_q;
  assign locked_out = locked_out_q;

endmodule

// File: tb/tb_cac_key_loader.sv
// Bench for cac_key_loader: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cac_key_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, s_valid, s_data;
  logic        s_ready, key_valid, busy, err_pulse, locked_out;
  logic [15:0] key_out;

  cac_key_loader #(.KEY_W(16), .MAX_FAIL(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .key_out(key_out), .key_valid(key_valid), .busy(busy),
    .err_pulse(err_pulse), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] fold(logic [15:0] k);
    int x = 0;
    for (int i = 0; i < 4; i++) x = x ^ int'((k >> (4 * i)) & 16'hF);
    return x[3:0];
  endfunction

  // Reference model: a frame is "active" from start until its verdict; the
  // verdict is taken one edge after the 20th bit has been collected.
  bit          m_active = 0, m_lock = 0, m_kv = 0, m_err = 0;
  int          m_n = 0, m_fail = 0;
  logic [15:0] m_shadow = '0, m_key = '0;
  logic [3:0]  m_chk = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_lock = 0; m_kv = 0; m_err = 0;
      m_n = 0; m_fail = 0; m_key = '0; m_shadow = '0; m_chk = '0;
    end else begin
      m_err = 0;
      if (m_lock) begin
      end else if (m_active && m_n == 20) begin
        m_active = 0;
        if (fold(m_shadow) == m_chk) begin
          m_key = m_shadow; m_kv = 1; m_fail = 0;
        end else begin
          m_err = 1; m_fail++;
          if (m_fail >= 3) m_lock = 1;
        end
      end else if (m_active) begin
        if (s_valid) begin
          if (m_n < 16) m_shadow[m_n] = s_data;
          else m_chk[m_n - 16] = s_data;
          m_n++;
        end
      end else if (start) begin
        m_active = 1; m_n = 0; m_key = '0; m_kv = 0;
      end
    end
  end

  int acc_bits = 0;
  int err_seen = 0;

  always @(negedge clk) begin
    check("key_out", key_out, m_key);
    check("key_valid", key_valid, m_kv);
    check("s_ready", s_ready, m_active && m_n < 20);
    check("busy", busy, m_active);
    check("err_pulse", err_pulse, m_err);
    check("locked_out", locked_out, m_lock);
    if (rst_n && s_valid && s_ready) acc_bits++;
    if (err_pulse) err_seen++;
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bits(logic [15:0] v, int w, int gmax);
    for (int i = 0; i < w; i++) begin
      repeat ($urandom_range(gmax, 0)) tick();
      s_valid = 1'b1; s_data = v[i];
      tick();
      s_valid = 1'b0; s_data = 1'b0;
    end
  endtask

  task automatic frame(logic [15:0] k, logic [3:0] c, int gmax);
    start = 1'b1; tick(); start = 1'b0;
    send_bits(k, 16, gmax);
    send_bits({12'b0, c}, 4, gmax);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick();
  endtask

  initial begin
    int e0;
    logic [15:0] k;
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 1'b0;
    tick(2);
    check("rst_key_out", key_out, 16'h0);
    check("rst_locked", locked_out, 1'b0);
    rst_n = 1'b1; tick();

    // good frame, no gaps, latency pin
    frame(16'h1234, 4'h4, 0);
    check("t1_kv_in_check", key_valid, 1'b0);
    check("t1_busy_in_check", busy, 1'b1);
    tick();
    check("t1_key", key_out, 16'h1234);
    check("t1_kv", key_valid, 1'b1);
    check("t1_busy_after", busy, 1'b0);
    check("t1_no_err", err_seen, 0);

    // same frame with random stalls
    acc_bits = 0;
    frame(16'h1234, 4'h4, 5);
    tick();
    check("t2_bits", acc_bits, 20);
    check("t2_key", key_out, 16'h1234);

    // bad frame after a good load
    e0 = err_seen;
    start = 1'b1; tick(); start = 1'b0;
    check("t3_key_zero_on_start", key_out, 16'h0);
    check("t3_kv_zero_on_start", key_valid, 1'b0);
    send_bits(16'hA5C3, 16, 2);
    send_bits(16'h0005, 4, 2);
    tick(3);
    check("t3_one_err", err_seen - e0, 1);
    check("t3_key_stays_zero", key_out, 16'h0);

    // clear the failure count, then three consecutive bad frames
    frame(16'h1234, 4'h4, 0); tick();
    for (int f = 0; f < 3; f++) begin
      frame(16'h00FF, 4'h1, 1); tick();
      if (f == 1) check("t4_not_locked_yet", locked_out, 1'b0);
    end
    check("t4_locked", locked_out, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check("t4_ready_locked", s_ready, 1'b0);
    send_bits(16'h1234, 16, 0); send_bits(16'h0004, 4, 0); tick(2);
    check("t4_key_locked", key_out, 16'h0);
    do_reset();
    check("t4_unlocked", locked_out, 1'b0);
    frame(16'h1234, 4'h4, 0); tick();
    check("t4_reload", key_out, 16'h1234);

    // bad, bad, good, bad, bad -> no lockout
    frame(16'h0F0F, 4'h3, 1); tick();
    frame(16'h0F0F, 4'h3, 1); tick();
    frame(16'h1234, 4'h4, 1); tick();
    check("t5_kv_good", key_valid, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_kv_drop_on_start", key_valid, 1'b0);
    send_bits(16'h0F0F, 16, 0); send_bits(16'h0003, 4, 0); tick();
    frame(16'h0F0F, 4'h3, 1); tick();
    check("t5_no_lock", locked_out, 1'b0);

    // reset after 9 key bits
    start = 1'b1; tick(); start = 1'b0;
    send_bits(16'h01FF, 9, 0);
    rst_n = 1'b0; #1;
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_ready", s_ready, 1'b0);
    check("t6_async_key", key_out, 16'h0);
    tick(); rst_n = 1'b1; tick();
    frame(16'hBEEF, fold(16'hBEEF), 2); tick();
    check("t6_clean_load", key_out, 16'hBEEF);
    check("t6_clean_kv", key_valid, 1'b1);

    // random frames, mostly good
    for (int r = 0; r < 30; r++) begin
      k = 16'($urandom);
      if ($urandom_range(3, 0) == 0) frame(k, fold(k) ^ 4'($urandom_range(15, 1)), 3);
      else frame(k, fold(k), 3);
      tick($urandom_range(3, 1));
      if (m_lock) do_reset();
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
